// File: rtl/div_ctrl.sv
// Division sequencer: hands operand magnitudes to an external divider core,
// restores the result signs into HI/LO, and owns the direct HI/LO writes.
module div_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        sign_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [31:0] div_divisor,
   input  logic        div_busy,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic [1:0]  dbg_state
);

   // Handshake: a request is taken on any rising edge where req && ready.
   // ready is high only in IDLE (including the done cycle); nothing is queued.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        finish;
   logic        b_zero;
   logic        q_neg;
   logic        r_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   assign b_zero    = (b == 32'd0);
   assign a_mag     = (sign_op && a[31]) ? (32'd0 - a) : a;
   assign b_mag     = (sign_op && b[31]) ? (32'd0 - b) : b;
   assign stall     = ~ready;
   assign dbg_state = state;

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      div_start = 1'b0;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            ready  = 1'b1;
            accept = req;
            if (req && !b_zero) state_nxt = START;
         end
         START: begin
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               div_start = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               state_nxt = IDLE;
            end else if (!div_busy) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Operand registers only change at accept, so the core sees stable inputs
   // from START until WAIT is left.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_dividend <= 32'd0;
         div_divisor  <= 32'd0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         hi           <= 32'd0;
         lo           <= 32'd0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            if (b_zero) begin
               lo   <= 32'hFFFF_FFFF;
               hi   <= a;
               done <= 1'b1;
            end else begin
               div_dividend <= a_mag;
               div_divisor  <= b_mag;
               q_neg        <= sign_op & (a[31] ^ b[31]);
               r_neg        <= sign_op & a[31];
            end
         end else if (finish) begin
            lo   <= q_neg ? (32'd0 - div_q) : div_q;
            hi   <= r_neg ? (32'd0 - div_r) : div_r;
            done <= 1'b1;
         end else if (state == IDLE) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider core, arithmetic reference model,
// and a scoreboard monitor that checks operands, results and done timing.
module tb_div_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic        sign_op = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        flush = 1'b0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic        ready, stall, done, div_start;
   logic [31:0] hi, lo, div_dividend, div_divisor;
   logic        core_busy;
   logic [31:0] core_q, core_r;
   logic [1:0]  dbg_state;
   int          core_cnt;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   logic [31:0] model_hi = 32'd0;
   logic [31:0] model_lo = 32'd0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_op_q[$];
   int          exp_t[$];

   div_ctrl dut (
      .clock(clock), .reset(reset), .req(req), .sign_op(sign_op), .a(a), .b(b),
      .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .ready(ready), .stall(stall), .done(done), .hi(hi), .lo(lo),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_busy(core_busy), .div_q(core_q), .div_r(core_r), .dbg_state(dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Divider core: result ready 32 cycles after the start cycle, restartable.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         core_busy <= 1'b0;
         core_cnt  <= 0;
         core_q    <= 32'd0;
         core_r    <= 32'd0;
      end else if (div_start) begin
         core_busy <= 1'b1;
         core_cnt  <= 30;
         core_q    <= (div_divisor != 0) ? div_dividend / div_divisor : 32'hFFFF_FFFF;
         core_r    <= (div_divisor != 0) ? div_dividend % div_divisor : div_dividend;
      end else if (core_busy) begin
         if (core_cnt == 0) core_busy <= 1'b0;
         else               core_cnt  <= core_cnt - 1;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] x,
                                           input logic [31:0] y);
      longint      n, d, q, r;
      logic [63:0] qv, rv;
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      n  = s ? longint'($signed(x)) : longint'({32'd0, x});
      d  = s ? longint'($signed(y)) : longint'({32'd0, y});
      q  = n / d;
      r  = n % d;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   function automatic logic [31:0] mag(input logic s, input logic [31:0] x);
      longint      v;
      logic [63:0] mv;
      v  = s ? longint'($signed(x)) : longint'({32'd0, x});
      if (v < 0) v = -v;
      mv = v;
      return mv[31:0];
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      if (!reset) begin
         if (div_start) begin
            if (exp_op_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL div_start: got unexpected pulse expected none (cycle %0d)", cyc);
            end else begin
               check("operands", {div_dividend, div_divisor}, exp_op_q.pop_front());
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL done: got unexpected pulse expected none (cycle %0d)", cyc);
            end else begin
               check("hi_lo", {hi, lo}, exp_q.pop_front());
               check("done_cycle", 64'(cyc), 64'(exp_t.pop_front()));
               check("ready_with_done", 64'(ready), 64'd1);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input bit push_res, input bit hold_we);
      int          t;
      int          acc;
      logic [63:0] r;
      t = 0;
      @(negedge clock);
      while (!ready && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (!ready) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1");
         return;
      end
      req = 1'b1; sign_op = s; a = x; b = y;
      if (hold_we) begin
         hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
      end
      @(posedge clock);
      #1;
      acc = cyc;
      req = 1'b0; a = $urandom; b = $urandom; sign_op = 1'($urandom_range(0, 1));
      r = ref_div(s, x, y);
      if (y != 32'd0) exp_op_q.push_back({mag(s, x), mag(s, y)});
      if (push_res) begin
         exp_q.push_back(r);
         exp_t.push_back(y == 32'd0 ? acc : acc + 33);
         model_hi = r[63:32];
         model_lo = r[31:0];
      end
      if (hold_we) begin
         t = 0;
         while (!done && t < 60) begin
            @(negedge clock);
            t++;
         end
         if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got done=0 expected done=1");
         end
         hi_we = 1'b0; lo_we = 1'b0;
      end
   endtask

   task automatic expect_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
      int t;
      t = 0;
      @(negedge clock);
      while (!ready && t < 100) begin
         @(negedge clock);
         t++;
      end
      check(nm, {hi, lo}, {eh, el});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] x, y;
      logic        s;
      repeat (3) @(negedge clock);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_div_start", 64'(div_start), 64'd0);
      check("rst_hi_lo", {hi, lo}, 64'd0);
      check("rst_operands", {div_dividend, div_divisor}, 64'd0);
      reset = 1'b0;

      do_op(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
      expect_hilo("divu_100_7", 32'd2, 32'd14);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
      expect_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op(1'b0, 32'd5, 32'd0, 1'b1, 1'b0);
      expect_hilo("divu_5_0", 32'd5, 32'hFFFF_FFFF);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      expect_hilo("div_overflow", 32'd0, 32'h8000_0000);

      // Flush ten cycles into WAIT, then a fresh request while the core is busy.
      do_op(1'b0, 32'd50, 32'd3, 1'b0, 1'b0);
      repeat (11) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      check("flush_ready", 64'(ready), 64'd1);
      check("flush_hi_lo", {hi, lo}, {model_hi, model_lo});
      do_op(1'b0, 32'd9, 32'd3, 1'b1, 1'b0);
      expect_hilo("divu_9_3", 32'd0, 32'd3);

      // Reset in the middle of WAIT.
      do_op(1'b1, $urandom, $urandom | 32'd1, 1'b0, 1'b0);
      repeat (15) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("midrst_ready", 64'(ready), 64'd1);
      check("midrst_stall", 64'(stall), 64'd0);
      check("midrst_hi_lo", {hi, lo}, 64'd0);
      model_hi = 32'd0; model_lo = 32'd0;
      @(negedge clock);
      reset = 1'b0;

      // Direct writes in IDLE.
      @(negedge clock);
      hi_we = 1'b1; wdata = 32'h1234;
      @(posedge clock);
      #1 hi_we = 1'b0;
      @(negedge clock);
      check("mthi", {hi, lo}, {32'h1234, model_lo});
      model_hi = 32'h1234;
      x = $urandom;
      lo_we = 1'b1; wdata = x;
      @(posedge clock);
      #1 lo_we = 1'b0;
      @(negedge clock);
      check("mtlo", {hi, lo}, {model_hi, x});
      model_lo = x;

      // Direct writes held across result writes: the result must win.
      do_op(1'b0, 32'd1000, 32'd10, 1'b1, 1'b1);
      do_op(1'b1, 32'hFFFF_FFF8, 32'd0, 1'b1, 1'b1);
      expect_hilo("we_vs_div0", 32'hFFFF_FFF8, 32'hFFFF_FFFF);

      // Randomised back-to-back traffic.
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom_range(0, 1));
         x = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: y = 32'hFFFF_FFFF;
            2: y = 32'($urandom_range(1, 9));
            3: begin x = 32'h8000_0000; y = $urandom; end
            default: y = $urandom;
         endcase
         do_op(s, x, y, 1'b1, 1'b0);
      end
      expect_hilo("final_hi_lo", model_hi, model_lo);
      repeat (3) @(negedge clock);
      check("results_left", 64'(exp_q.size()), 64'd0);
      check("starts_left", 64'(exp_op_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1);
   end

endmodule
